mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 20 ++
 rtl/prescaler.sv | 43 ++++
 rtl/mod_counter.sv | 90 +++++++++
 tb/tb_mod_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the mod_counter slice: count direction, terminal-count mode,
// and a helper for sizing small counters.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prescaler.sv
// Enabled-cycle prescaler: tick is high while the count sits at PRESCALE-1,
// so a step happens once every PRESCALE enabled cycles.
module prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_param_check
        $error("prescaler: PRESCALE must be in 1..65536");
    end

    localparam int unsigned    CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, synchronous load, wrap or saturate at
// the terminal value, combinational terminal-count flag and registered wrap pulse.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1,
    parameter int unsigned     SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) ||
        PRESCALE < 1 || SATURATE > 1) begin : g_param_check
        $error("mod_counter: illegal WIDTH/MODULUS/PRESCALE/SATURATE combination");
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
    localparam mode_e            MODE = (SATURATE == 1) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             step;

    prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    assign step = enable & tick;

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            // Out-of-range load values clamp to the terminal so out never exceeds MODULUS-1.
            out_d = (load_value > TERM) ? TERM : load_value;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (out_q == TERM) begin
                    if (MODE == MODE_WRAP) begin
                        out_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (out_q == '0) begin
                    if (MODE == MODE_WRAP) begin
                        out_d  = TERM;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign tc   = (up == DIR_UP) ? (out_q == TERM) : (out_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: four parameterisations share one stimulus stream,
// a behavioural model queues expected outputs per edge, and a monitor compares them.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] load_value;

    logic [3:0] o0, o1, o2, o3;
    logic       tc0, tc1, tc2, tc3;
    logic       w0, w1, w2, w3;

    always #5 clk = ~clk;

    // d0 defaults, d1 MODULUS=10 wrap, d2 MODULUS=10 saturate, d3 PRESCALE=3
    mod_counter d0 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(o0), .tc(tc0), .wrap(w0)
    );
    mod_counter #(.MODULUS(10)) d1 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(o1), .tc(tc1), .wrap(w1)
    );
    mod_counter #(.MODULUS(10), .SATURATE(1)) d2 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(o2), .tc(tc2), .wrap(w2)
    );
    mod_counter #(.PRESCALE(3)) d3 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(o3), .tc(tc3), .wrap(w3)
    );

    localparam int NI = 4;
    localparam int M [NI] = '{16, 10, 10, 16};
    localparam int P [NI] = '{1, 1, 1, 3};
    localparam int S [NI] = '{0, 0, 1, 0};

    typedef struct {
        int inst;
        int out;
        bit tc;
        bit wrap;
    } exp_t;

    exp_t sb[$];
    int   m_out [NI];
    int   m_pc  [NI];
    bit   m_wrap[NI];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        if (reset) begin
            m_out[i] = 0; m_pc[i] = 0; m_wrap[i] = 0;
        end else if (load) begin
            m_out[i]  = (int'(load_value) >= M[i]) ? M[i] - 1 : int'(load_value);
            m_pc[i]   = 0;
            m_wrap[i] = 0;
        end else begin
            m_wrap[i] = 0;
            if (enable) begin
                if (m_pc[i] < P[i] - 1) begin
                    m_pc[i]++;
                end else begin
                    m_pc[i] = 0;
                    if (up) begin
                        if (m_out[i] < M[i] - 1) m_out[i]++;
                        else if (S[i] == 0) begin m_out[i] = 0; m_wrap[i] = 1; end
                    end else begin
                        if (m_out[i] > 0) m_out[i]--;
                        else if (S[i] == 0) begin m_out[i] = M[i] - 1; m_wrap[i] = 1; end
                    end
                end
            end
        end
    endtask

    // Apply inputs for one edge, queue the model's post-edge view, wait past the edge.
    task automatic drive(input bit r, input bit en, input bit u, input bit ld, input int lv);
        exp_t e;
        reset = r; enable = en; up = u; load = ld; load_value = 4'(lv);
        for (int i = 0; i < NI; i++) begin
            model_edge(i);
            e.inst = i;
            e.out  = m_out[i];
            e.tc   = up ? (m_out[i] == M[i] - 1) : (m_out[i] == 0);
            e.wrap = m_wrap[i];
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    function automatic int got_out(input int i);
        case (i)
            0: return int'(o0);
            1: return int'(o1);
            2: return int'(o2);
            default: return int'(o3);
        endcase
    endfunction

    function automatic bit got_tc(input int i);
        case (i)
            0: return tc0;
            1: return tc1;
            2: return tc2;
            default: return tc3;
        endcase
    endfunction

    function automatic bit got_wrap(input int i);
        case (i)
            0: return w0;
            1: return w1;
            2: return w2;
            default: return w3;
        endcase
    endfunction

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("sb_d%0d_out", mon_e.inst), got_out(mon_e.inst), mon_e.out);
            chk($sformatf("sb_d%0d_tc", mon_e.inst), got_tc(mon_e.inst), mon_e.tc);
            chk($sformatf("sb_d%0d_wrap", mon_e.inst), got_wrap(mon_e.inst), mon_e.wrap);
        end
    end

    initial begin
        // Count up through the default range.
        drive(1, 1, 1, 0, 0);
        chk("rst_out", o0, 0);
        chk("rst_wrap", w0, 0);
        chk("rst_tc_up", tc0, 0);
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 1, 0, 0);
            chk("up16_out", o0, k % 16);
            chk("up16_tc", tc0, (k % 16) == 15);
            chk("up16_wrap", w0, k == 16);
        end

        // Count down with MODULUS=10.
        drive(1, 1, 0, 0, 0);
        chk("rst_tc_down", tc1, 1);
        chk("rst_out_d1", o1, 0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 1, 0, 0, 0);
            chk("dn10_out", o1, (10 - k % 10) % 10);
            chk("dn10_wrap", w1, (k == 1) || (k == 11));
            chk("dn10_tc", tc1, (k % 10) == 0);
        end

        // Saturating variant holds at 9, then steps down.
        drive(1, 1, 1, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 1, 1, 0, 0);
            chk("sat_out", o2, (k < 9) ? k : 9);
            chk("sat_wrap", w2, 0);
        end
        drive(0, 1, 0, 0, 0);
        chk("sat_down", o2, 8);

        // Prescale by 3 with a two-cycle enable gap mid-prescale.
        drive(1, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0); chk("pre_e1", o3, 0);
        drive(0, 1, 1, 0, 0); chk("pre_e2", o3, 0);
        drive(0, 1, 1, 0, 0); chk("pre_e3", o3, 1);
        drive(0, 1, 1, 0, 0); chk("pre_e4", o3, 1);
        drive(0, 0, 1, 0, 0); chk("pre_hold1", o3, 1);
        drive(0, 0, 1, 0, 0); chk("pre_hold2", o3, 1);
        drive(0, 1, 1, 0, 0); chk("pre_e5", o3, 1);
        drive(0, 1, 1, 0, 0); chk("pre_e6", o3, 2);

        // Load beats step; out-of-range values clamp; prescaler restarts.
        drive(0, 1, 1, 1, 12);
        chk("ld_clamp", o1, 9);
        chk("ld_wrap", w1, 0);
        chk("ld_d0", o0, 12);
        chk("ld_d3", o3, 12);
        drive(0, 1, 1, 0, 0); chk("ld_pre1", o3, 12);
        drive(0, 1, 1, 0, 0); chk("ld_pre2", o3, 12);
        drive(0, 1, 1, 0, 0); chk("ld_pre3", o3, 13);
        drive(0, 0, 1, 1, 10);
        chk("ld_eq_mod", o1, 9);
        chk("ld_d0_10", o0, 10);

        // Reset overrides load and enable.
        drive(1, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) drive(0, 1, 1, 0, 0);
        chk("rst_pre7", o0, 7);
        drive(1, 1, 1, 1, 5);
        chk("rst_over_ld", o0, 0);
        chk("rst_over_wrap", w0, 0);
        drive(0, 1, 1, 0, 0);
        chk("rst_resume", o0, 1);

        // Random traffic, checked by the scoreboard only.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 15)));
        end

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
